// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: drives active-low column selects, samples synchronized
// active-low rows into a frame, and debounces single-key frames into press/release events.
module keypad_scanner #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clks,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned SLOT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  DEB_N     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } state_e;

  logic [3:0]        rows_s1_q, rows_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        cols_q, cols_d;
  logic [15:0]       frame_q, frame_d;
  logic              frame_done_q, frame_done_d;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [3:0]        cand_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              key_down_q;

  logic [4:0]        ones_c;
  logic [3:0]        idx_c;
  logic              is_none_c;
  logic              is_single_c;

  // Two-flop row synchronizer; idle rows read as all-open.
  always_ff @(posedge clks or posedge rst) begin
    if (rst) begin
      rows_s1_q <= 4'hF;
      rows_s2_q <= 4'hF;
    end else begin
      rows_s1_q <= rows;
      rows_s2_q <= rows_s1_q;
    end
  end

  // Column sequencer and frame capture on the last cycle of each slot.
  always_comb begin
    slot_d       = slot_q + 1'b1;
    col_d        = col_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    if (slot_q == SLOT_LAST) begin
      slot_d                       = '0;
      col_d                        = col_q + 2'd1;
      frame_d[{col_q, 2'b00} +: 4] = ~rows_s2_q;
      frame_done_d                 = (col_q == 2'd3);
    end
    cols_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clks or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      col_q        <= 2'd0;
      cols_q       <= 4'b1110;
      frame_q      <= 16'h0000;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      col_q        <= col_d;
      cols_q       <= cols_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame classification: population count and index of the (last) set bit.
  always_comb begin
    ones_c = 5'd0;
    idx_c  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        ones_c = ones_c + 5'd1;
        idx_c  = 4'(i);
      end
    end
    is_none_c   = (ones_c == 5'd0);
    is_single_c = (ones_c == 5'd1);
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Debounce FSM, advancing once per completed frame.
  always_ff @(posedge clks or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_done_q) begin
        case (state_q)
          IDLE: begin
            if (is_single_c) begin
              cand_q <= idx_c;
              if (CNT_ONE == DEB_N) begin
                state_q     <= PRESSED;
                cnt_q       <= '0;
                key_code_q  <= idx_c;
                key_down_q  <= 1'b1;
                key_valid_q <= 1'b1;
              end else begin
                state_q <= CHECK;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          CHECK: begin
            if (is_single_c && (idx_c == cand_q)) begin
              if (cnt_inc == DEB_N) begin
                state_q     <= PRESSED;
                cnt_q       <= '0;
                key_code_q  <= cand_q;
                key_down_q  <= 1'b1;
                key_valid_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          PRESSED: begin
            if (is_none_c) begin
              if (CNT_ONE == DEB_N) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_down_q <= 1'b0;
              end else begin
                state_q <= RELEASE;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          RELEASE: begin
            if (is_none_c) begin
              if (cnt_inc == DEB_N) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_down_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
